signed_mult8: RTL and testbench
===============================

SIGNED_MULT8 -- requirements
Module: signed_mult8

Interface
REQ-001 The block SHALL expose the following ports:
- clk, input, 1 bit: single clock; all state updates on its rising edge.
- rst, input, 1 bit: asynchronous reset, active-high.
- start, input, 1 bit: request to begin a multiply; sampled on a clk rising edge.
- a, input, 8 bits: two's-complement multiplicand.
- b, input, 8 bits: two's-complement multiplier.
- product, output, 16 bits: two's-complement result, registered.
- busy, output, 1 bit: high while an operation is in progress.
- done, output, 1 bit: one-cycle pulse marking a new valid product.
REQ-002 The block SHALL have one clock (clk) and an asynchronous, active-high reset (rst); no other clock or reset input SHALL exist.

Function
REQ-003 The block SHALL implement a four-state machine: IDLE, RUN, SIGN, OUT.
REQ-004 In IDLE with start=1 at a rising edge, the block SHALL capture the following, then move to RUN:
- mag_a = two's-complement negation of a if a[7]=1, else a (8-bit unsigned; 0x80 gives 128).
- mag_b, derived from b the same way.
- neg = a[7] XOR b[7].
- 16-bit accumulator cleared to 0.
- 3-bit iteration counter cleared to 0.
REQ-005 In IDLE with start=0, all internal registers SHALL hold their values.
REQ-006 Each RUN cycle SHALL perform one shift-add step:
- if bit[counter] of mag_b is 1, add (mag_a << counter) to the accumulator.
- increment the counter.
- after the 8th step (counter was 7), move to SIGN.
REQ-007 In SIGN, the block SHALL do one of the following, then move to OUT:
- neg=1: load product with the 16-bit two's-complement negation of the accumulator (invert all bits, add 1, carry out of bit 15 discarded).
- neg=0: load product with the accumulator.
REQ-008 In OUT, done SHALL be 1 for exactly that one cycle, and the state SHALL return to IDLE at the next edge.
REQ-009 Latency: start accepted at edge N gives product valid and done=1 in the cycle following edge N+9, independent of operand values.
REQ-010 busy SHALL be 1 whenever the state is RUN, SIGN, or OUT, and 0 in IDLE.
REQ-011 start while busy=1 SHALL be ignored, and changes on a or b while busy=1 SHALL NOT affect the result in flight.
REQ-012 product SHALL hold its last value from the end of OUT until the next SIGN state; it SHALL NOT change during RUN.
REQ-013 A zero operand SHALL yield product 0x0000 regardless of neg.
REQ-014 The full signed range SHALL be exact with no overflow; -128 x -128 = 0x4000.
REQ-015 done and busy SHALL be driven from registered state only, with no combinational path from start.

Reset
REQ-016 While rst=1, regardless of clk, the block SHALL force:
- state = IDLE.
- product = 0x0000.
- busy = 0, done = 0.
- accumulator = 0, counter = 0, neg = 0.
REQ-017 rst asserted mid-operation SHALL abort the operation, with no done pulse for the aborted multiply.
REQ-018 The first start accepted after rst deasserts SHALL behave per REQ-004.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Unsigned: a=3, b=5, start pulse -> done in the cycle after edge N+9, product=0x000F, busy high for 9 cycles.
- Mixed sign: a=0xFD (-3), b=5 -> product=0xFFF1; a=0x80 (-128), b=0x7F (127) -> product=0xC080.
- Both minimum: a=0x80, b=0x80 -> product=0x4000; a=0x00, b=0xF9 (-7) -> product=0x0000.
- Start while busy: second start pulse with a=2, b=2 at edge N+4 -> ignored; only one done pulse; product = first result.
- Reset mid-operation: rst pulse at edge N+5 -> product=0x0000, busy=0, done stays 0; a new start afterwards gives a correct result after 10 cycles.
- Back-to-back: start held high continuously -> a new operation is accepted in the IDLE cycle after each OUT; done pulses every 11 cycles.

Source files
------------

// File: rtl/signed_mult8.sv
// 8x8 two's-complement multiplier: magnitudes are multiplied by an 8-step
// shift-add loop, then the sign is applied. Fixed 10-cycle occupancy per operation.
module signed_mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  mag_a;
  logic [7:0]  mag_b;
  logic        neg;
  logic [15:0] acc;
  logic [2:0]  cnt;

  // Handshake: start is only sampled in IDLE (busy=0); a start seen while
  // busy=1 is dropped. done is a one-cycle pulse in the cycle product becomes
  // valid, and product then holds until the next operation reaches SIGN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // 0x80 negates to 0x80, which reads correctly as unsigned 128
            mag_a <= a[7] ? (~a + 8'd1) : a;
            mag_b <= b[7] ? (~b + 8'd1) : b;
            neg   <= a[7] ^ b[7];
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (mag_b[cnt]) begin
            acc <= acc + ({8'd0, mag_a} << cnt);
          end
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          product <= neg ? (~acc + 16'd1) : acc;
          done    <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_signed_mult8.sv
// Bench for signed_mult8: directed corner cases plus random traffic, all
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_signed_mult8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  signed_mult8 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .product   (product),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase = -1 when idle, else number of edges since the accepting edge.
  // Result appears at edge 9, done in the following cycle, idle again at edge 10.
  int          phase = -1;
  int          prod_int;
  logic [15:0] pending = '0;
  logic [15:0] m_product = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     = -1;
      m_product = '0;
    end else if (phase == -1) begin
      if (start) begin
        prod_int = int'($signed(a)) * int'($signed(b));
        pending  = prod_int[15:0];
        phase    = 0;
      end
    end else if (phase == 9) begin
      phase = -1;
    end else begin
      phase = phase + 1;
      if (phase == 9) m_product = pending;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, phase >= 0});
      chk("done", {31'd0, done}, {31'd0, phase == 9});
      chk("product", {16'd0, product}, {16'd0, m_product});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic [15:0] exp, input string nm);
    int k;
    int busy_cnt;
    @(posedge clk); #1;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    k = 0;
    busy_cnt = 0;
    while (k < 20) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
      k++;
    end
    if (k >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: done never seen within 20 cycles", nm);
    end else begin
      chk({nm, "_product"}, {16'd0, product}, {16'd0, exp});
      chk({nm, "_latency"}, k, 32'd9);
      chk({nm, "_busy_cycles"}, busy_cnt, 32'd9);
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_done;
    int last_idx;
    int pulses;
    logic [7:0] corners [5];
    corners[0] = 8'h80; corners[1] = 8'h7F; corners[2] = 8'h00;
    corners[3] = 8'hFF; corners[4] = 8'h01;

    // reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_product", {16'd0, product}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // directed products
    do_op(8'd3,  8'd5,  16'h000F, "unsigned_3x5");
    do_op(8'hFD, 8'd5,  16'hFFF1, "mixed_m3x5");
    do_op(8'h80, 8'h7F, 16'hC080, "mixed_m128x127");
    do_op(8'h80, 8'h80, 16'h4000, "min_x_min");
    do_op(8'h00, 8'hF9, 16'h0000, "zero_x_m7");
    do_op(8'hFF, 8'hFF, 16'h0001, "m1_x_m1");

    // start while busy: second request at edge N+4 must be dropped
    @(posedge clk); #1;
    a = 8'd7; b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a = 8'd2; b = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    count_dones(20, n_done);
    chk("busy_start_dones", n_done, 32'd1);
    chk("busy_start_product", {16'd0, product}, 32'h003F);

    // reset mid-operation at edge N+5
    @(posedge clk); #1;
    a = 8'd100; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_product", {16'd0, product}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_dones(15, n_done);
    chk("midrst_no_done", n_done, 32'd0);
    do_op(8'h9C, 8'h64, 16'hD8F0, "after_rst_m100x100");

    // back-to-back: start held high, done every 11 cycles
    @(posedge clk); #1;
    start = 1'b1;
    last_idx = -1;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) begin
        if (last_idx >= 0) chk("b2b_interval", i - last_idx, 32'd11);
        last_idx = i;
        pulses++;
      end
      @(posedge clk); #1;
      a = 8'($urandom);
      b = 8'($urandom);
    end
    chk("b2b_pulses_ge5", {31'd0, pulses >= 5}, 32'd1);
    start = 1'b0;
    repeat (12) @(posedge clk);

    // random traffic, with corner operands mixed in
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : 8'($urandom);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
